// File: rtl/axim_write_burst_gen.sv
// axim_write_burst_gen: AXI write-master pattern generator, NUM_BURSTS incrementing bursts of incrementing data per run.
// Latency: busy 4 clk after start_trigger rises, AW/W valid 1 clk later; next burst 1 clk after accepted bresp.
// Backpressure: valids held with stable payload until ready; one burst outstanding. Optional: AXIM_WR_ABORT_ON_ERR_EN.
module axim_write_burst_gen #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 25,
  parameter int BURST_LEN  = 32,
  parameter int NUM_BURSTS = 4,
  parameter int START_ADDR = 0,
  parameter int SEED       = 100
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start_trigger,
  output logic              busy_out,
  output logic              done_out,
  output logic              error_out,
  input  logic              axi_awready_in,
  output logic              axi_awvalid_out,
  output logic [7:0]        axi_awlen_out,
  output logic [ADDR_W-1:0] axi_awaddr_out,
  input  logic              axi_wready_in,
  output logic              axi_wvalid_out,
  output logic [DATA_W-1:0] axi_wdata_out,
  output logic              axi_wlast_out,
  output logic              axi_bready_out,
  input  logic              axi_bvalid_in,
  input  logic [1:0]        axi_bresp_in
);

  localparam logic [7:0]        LP_LEN_M1    = 8'(BURST_LEN - 1);
  localparam logic [15:0]       LP_BURSTS_M1 = 16'(NUM_BURSTS - 1);
  localparam logic [ADDR_W-1:0] LP_ADDR_INC  = ADDR_W'(BURST_LEN);
  localparam logic [ADDR_W-1:0] LP_START     = ADDR_W'(START_ADDR);
  localparam logic [DATA_W-1:0] LP_SEED      = DATA_W'(SEED);
  localparam logic [DATA_W-1:0] LP_DATA_ONE  = DATA_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP, S_FINISH} state_t;

  state_t              r_state;
  logic                r_sync1, r_sync2, r_sync_d, r_start_edge;
  logic                r_launch, r_busy, r_done, r_error;
  logic                r_awvalid, r_aw_done;
  logic [ADDR_W-1:0]   r_awaddr;
  logic                r_wvalid, r_wlast, r_w_done;
  logic [DATA_W-1:0]   r_wdata;
  logic [7:0]          r_beat_cnt;
  logic                r_bready;
  logic [15:0]         r_burst_cnt;
  logic                w_bresp_err, w_end_run;

  // Synchronise the asynchronous trigger and register its rising edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1      <= 1'b0;
      r_sync2      <= 1'b0;
      r_sync_d     <= 1'b0;
      r_start_edge <= 1'b0;
    end else begin
      r_sync1      <= start_trigger;
      r_sync2      <= r_sync1;
      r_sync_d     <= r_sync2;
      r_start_edge <= r_sync2 & ~r_sync_d;
    end
  end

  // Decide whether the response being accepted ends the run
  always_comb begin
    w_bresp_err = (axi_bresp_in != 2'b00);
`ifdef AXIM_WR_ABORT_ON_ERR_EN
    w_end_run = (r_burst_cnt == '0) || w_bresp_err;
`else
    w_end_run = (r_burst_cnt == '0);
`endif
  end

  // Run control plus the AW and W channel sub-machines, all outputs registered
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_launch    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_awvalid   <= 1'b0;
      r_aw_done   <= 1'b0;
      r_awaddr    <= LP_START;
      r_wvalid    <= 1'b0;
      r_wlast     <= 1'b0;
      r_w_done    <= 1'b0;
      r_wdata     <= LP_SEED;
      r_beat_cnt  <= '0;
      r_bready    <= 1'b0;
      r_burst_cnt <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_start_edge) begin
            r_error     <= 1'b0;
            r_awaddr    <= LP_START;
            r_wdata     <= LP_SEED;
            r_burst_cnt <= LP_BURSTS_M1;
            r_busy      <= 1'b1;
            r_launch    <= 1'b1;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (r_launch) begin
            // First cycle of a burst: raise both valids together
            r_launch   <= 1'b0;
            r_awvalid  <= 1'b1;
            r_aw_done  <= 1'b0;
            r_wvalid   <= 1'b1;
            r_wlast    <= (BURST_LEN == 1);
            r_beat_cnt <= LP_LEN_M1;
            r_w_done   <= 1'b0;
          end else begin
            if (r_awvalid && axi_awready_in) begin
              r_awvalid <= 1'b0;
              r_aw_done <= 1'b1;
            end
            if (r_wvalid && axi_wready_in) begin
              r_wdata <= r_wdata + LP_DATA_ONE;
              if (r_wlast) begin
                r_wvalid <= 1'b0;
                r_wlast  <= 1'b0;
                r_w_done <= 1'b1;
              end else begin
                r_beat_cnt <= r_beat_cnt - 8'd1;
                r_wlast    <= (r_beat_cnt == 8'd1);
              end
            end
            if (r_aw_done && r_w_done) begin
              r_bready <= 1'b1;
              r_state  <= S_RESP;
            end
          end
        end
        S_RESP: begin
          if (axi_bvalid_in) begin
            r_bready <= 1'b0;
            if (w_bresp_err) r_error <= 1'b1;
            if (w_end_run) begin
              r_state <= S_FINISH;
            end else begin
              r_burst_cnt <= r_burst_cnt - 16'd1;
              r_awaddr    <= r_awaddr + LP_ADDR_INC;
              r_launch    <= 1'b1;
              r_state     <= S_ISSUE;
            end
          end
        end
        S_FINISH: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy_out        = r_busy;
  assign done_out        = r_done;
  assign error_out       = r_error;
  assign axi_awvalid_out = r_awvalid;
  assign axi_awlen_out   = LP_LEN_M1;
  assign axi_awaddr_out  = r_awaddr;
  assign axi_wvalid_out  = r_wvalid;
  assign axi_wdata_out   = r_wdata;
  assign axi_wlast_out   = r_wlast;
  assign axi_bready_out  = r_bready;

endmodule

// File: tb/tb_axim_write_burst_gen.sv
`timescale 1ns/1ps
module tb_axim_write_burst_gen;
  localparam int DW = 16;
  localparam int AW = 25;
  localparam int BL = 32;
  localparam int NB = 4;
`ifdef AXIM_WR_ABORT_ON_ERR_EN
  localparam int ERR_BURSTS = 2;
`else
  localparam int ERR_BURSTS = 4;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start_trigger = 1'b0;
  logic awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
  logic [1:0] bresp = 2'b00;
  logic busy, done, error, awvalid, wvalid, wlast, bready;
  logic [7:0] awlen;
  logic [AW-1:0] awaddr;
  logic [DW-1:0] wdata;

  logic start1 = 1'b0;
  logic busy1, done1, error1, awvalid1, wvalid1, wlast1, bready1;
  logic [7:0] awlen1;
  logic [AW-1:0] awaddr1;
  logic [DW-1:0] wdata1;

  always #5 clk = ~clk;

  axim_write_burst_gen #(.DATA_W(DW), .ADDR_W(AW), .BURST_LEN(BL), .NUM_BURSTS(NB),
                         .START_ADDR(0), .SEED(100)) u_dut (
    .clk(clk), .reset_n(reset_n), .start_trigger(start_trigger),
    .busy_out(busy), .done_out(done), .error_out(error),
    .axi_awready_in(awready), .axi_awvalid_out(awvalid), .axi_awlen_out(awlen),
    .axi_awaddr_out(awaddr), .axi_wready_in(wready), .axi_wvalid_out(wvalid),
    .axi_wdata_out(wdata), .axi_wlast_out(wlast), .axi_bready_out(bready),
    .axi_bvalid_in(bvalid), .axi_bresp_in(bresp));

  axim_write_burst_gen #(.DATA_W(DW), .ADDR_W(AW), .BURST_LEN(1), .NUM_BURSTS(3),
                         .START_ADDR(0), .SEED(100)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .start_trigger(start1),
    .busy_out(busy1), .done_out(done1), .error_out(error1),
    .axi_awready_in(1'b1), .axi_awvalid_out(awvalid1), .axi_awlen_out(awlen1),
    .axi_awaddr_out(awaddr1), .axi_wready_in(1'b1), .axi_wvalid_out(wvalid1),
    .axi_wdata_out(wdata1), .axi_wlast_out(wlast1), .axi_bready_out(bready1),
    .axi_bvalid_in(1'b1), .axi_bresp_in(2'b00));

  // scoreboard queues: expected AW addresses and {wlast, wdata} beats
  logic [AW-1:0] q_aw[$];
  logic [DW:0]   q_w[$];
  logic [AW-1:0] q_aw1[$];
  logic [DW:0]   q_w1[$];

  int n_vec = 0, n_err = 0;
  int done_cnt = 0, done1_cnt = 0, b_cnt = 0;
  int bad_burst = -1;
  bit stall_en = 0, aw_late = 0, w_burst_done = 0;

  task automatic mon_loop();
    bit p_aw_stall = 0, p_w_stall = 0;
    logic [AW-1:0] p_awaddr, ea;
    logic [DW:0] p_w, ew;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        p_aw_stall = 0; p_w_stall = 0; w_burst_done = 0;
      end else begin
        if (p_aw_stall) begin
          n_vec++;
          if (awvalid !== 1'b1 || awaddr !== p_awaddr) begin
            n_err++;
            $display("FAIL aw_hold: awvalid=%b awaddr=%0d, required 1/%0d", awvalid, awaddr, p_awaddr);
          end
        end
        if (p_w_stall) begin
          n_vec++;
          if (wvalid !== 1'b1 || {wlast, wdata} !== p_w) begin
            n_err++;
            $display("FAIL w_hold: wvalid=%b beat=%h, required 1/%h", wvalid, {wlast, wdata}, p_w);
          end
        end
        if (awvalid && awready) begin
          n_vec++;
          w_burst_done = 0;
          if (q_aw.size() == 0) begin
            n_err++;
            $display("FAIL aw_extra: awaddr=%0d, required no address", awaddr);
          end else begin
            ea = q_aw.pop_front();
            if (awaddr !== ea) begin
              n_err++;
              $display("FAIL aw_addr: got %0d, required %0d", awaddr, ea);
            end
          end
        end
        if (wvalid && wready) begin
          n_vec++;
          if (wlast) w_burst_done = 1;
          if (q_w.size() == 0) begin
            n_err++;
            $display("FAIL w_extra: beat=%h, required no beat", {wlast, wdata});
          end else begin
            ew = q_w.pop_front();
            if ({wlast, wdata} !== ew) begin
              n_err++;
              $display("FAIL w_beat: got last/data %b/%0d, required %b/%0d", wlast, wdata, ew[DW], ew[DW-1:0]);
            end
          end
        end
        if (bready && bvalid) b_cnt++;
        if (done) done_cnt++;
        p_aw_stall = awvalid && !awready; p_awaddr = awaddr;
        p_w_stall  = wvalid && !wready;   p_w = {wlast, wdata};
        // second instance (BURST_LEN=1, always ready)
        if (awvalid1) begin
          n_vec++;
          ea = (q_aw1.size() != 0) ? q_aw1.pop_front() : '1;
          if (awaddr1 !== ea) begin
            n_err++;
            $display("FAIL aw1_addr: got %0d, required %0d", awaddr1, ea);
          end
        end
        if (wvalid1) begin
          n_vec++;
          ew = (q_w1.size() != 0) ? q_w1.pop_front() : '1;
          if ({wlast1, wdata1} !== ew) begin
            n_err++;
            $display("FAIL w1_beat: got last/data %b/%0d, required %b/%0d", wlast1, wdata1, ew[DW], ew[DW-1:0]);
          end
        end
        if (done1) done1_cnt++;
      end
    end
  endtask

  task automatic drv_loop();
    forever begin
      @(posedge clk);
      #1;
      if (stall_en) begin
        wready = 1'($urandom_range(0, 1));
        awready = aw_late ? w_burst_done : 1'($urandom_range(0, 1));
        bvalid = 1'($urandom_range(0, 1));
      end else begin
        wready = 1'b1;
        awready = aw_late ? w_burst_done : 1'b1;
        bvalid = 1'b1;
      end
      bresp = (b_cnt == bad_burst) ? 2'b10 : 2'b00;
    end
  endtask

  task automatic push_run(input int bursts);
    logic [DW-1:0] d = 16'd100;
    for (int b = 0; b < bursts; b++) begin
      q_aw.push_back(AW'(b * BL));
      for (int i = 0; i < BL; i++) begin
        q_w.push_back({(i == BL - 1), d});
        d = d + 16'd1;
      end
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #2 start_trigger = 1'b1;
    repeat (2) @(posedge clk);
    #2 start_trigger = 1'b0;
  endtask

  task automatic wait_done(input int d0, output bit ok);
    int c = 0;
    while (done_cnt == d0 && c < 4000) begin @(posedge clk); c++; end
    repeat (3) @(posedge clk);
    #1 ok = (done_cnt != d0);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({awvalid, wvalid, wlast, bready, busy, done, error} !== 7'b0) begin
      n_err++; $display("FAIL reset_ctrl: got %b, required 0000000", {awvalid, wvalid, wlast, bready, busy, done, error});
    end
    n_vec++;
    if (awaddr !== '0 || wdata !== 16'd100) begin
      n_err++; $display("FAIL reset_payload: addr/data %0d/%0d, required 0/100", awaddr, wdata);
    end
    n_vec++;
    if (awlen !== 8'd31 || awlen1 !== 8'd0) begin
      n_err++; $display("FAIL reset_awlen: %0d/%0d, required 31/0", awlen, awlen1);
    end
    @(posedge clk); #2 reset_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_basic();
    int d0 = done_cnt, b0 = b_cnt, c = 0, busy_c = -1, aw_c = -1;
    bit ok;
    stall_en = 0; aw_late = 0;
    push_run(NB);
    @(posedge clk); #1 start_trigger = 1'b1;
    while (c < 20 && aw_c < 0) begin
      @(posedge clk); c++; #1;
      if (busy && busy_c < 0) busy_c = c;
      if (awvalid && aw_c < 0) aw_c = c;
    end
    start_trigger = 1'b0;
    n_vec++;
    if (busy_c != 4 || aw_c != 5) begin
      n_err++; $display("FAIL start_latency: busy/awvalid at clk %0d/%0d, required 4/5", busy_c, aw_c);
    end
    wait_done(d0, ok);
    n_vec++;
    if (!ok || done_cnt - d0 != 1) begin n_err++; $display("FAIL basic_done: pulses %0d, required 1", done_cnt - d0); end
    n_vec++;
    if (b_cnt - b0 != NB || q_aw.size() + q_w.size() != 0) begin
      n_err++; $display("FAIL basic_count: bresp %0d left %0d, required %0d/0", b_cnt - b0, q_aw.size() + q_w.size(), NB);
    end
    n_vec++;
    if (error !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL basic_flags: error/busy %b/%b, required 0/0", error, busy); end
  endtask

  task automatic test_stall(input bit late);
    int d0 = done_cnt, b0 = b_cnt;
    bit ok;
    stall_en = 1; aw_late = late;
    push_run(NB);
    pulse_start();
    wait_done(d0, ok);
    stall_en = 0; aw_late = 0;
    n_vec++;
    if (!ok || done_cnt - d0 != 1) begin n_err++; $display("FAIL stall%0d_done: pulses %0d, required 1", late, done_cnt - d0); end
    n_vec++;
    if (b_cnt - b0 != NB || q_aw.size() + q_w.size() != 0) begin
      n_err++; $display("FAIL stall%0d_count: bresp %0d left %0d, required %0d/0", late, b_cnt - b0, q_aw.size() + q_w.size(), NB);
    end
  endtask

  task automatic test_burst1();
    int d0 = done1_cnt, c = 0;
    for (int i = 0; i < 3; i++) begin
      q_aw1.push_back(AW'(i));
      q_w1.push_back({1'b1, 16'(100 + i)});
    end
    @(posedge clk); #2 start1 = 1'b1;
    repeat (2) @(posedge clk);
    #2 start1 = 1'b0;
    while (done1_cnt == d0 && c < 200) begin @(posedge clk); c++; end
    repeat (3) @(posedge clk);
    n_vec++;
    if (done1_cnt - d0 != 1 || q_aw1.size() + q_w1.size() != 0 || error1 !== 1'b0) begin
      n_err++; $display("FAIL burst1_run: done %0d left %0d error %b, required 1/0/0", done1_cnt - d0, q_aw1.size() + q_w1.size(), error1);
    end
  endtask

  task automatic test_error();
    int d0 = done_cnt, b0 = b_cnt;
    bit ok;
    bad_burst = b_cnt + 1;
    push_run(ERR_BURSTS);
    pulse_start();
    wait_done(d0, ok);
    bad_burst = -1;
    n_vec++;
    if (!ok || done_cnt - d0 != 1) begin n_err++; $display("FAIL err_done: pulses %0d, required 1", done_cnt - d0); end
    n_vec++;
    if (b_cnt - b0 != ERR_BURSTS || q_aw.size() + q_w.size() != 0) begin
      n_err++; $display("FAIL err_count: bresp %0d left %0d, required %0d/0", b_cnt - b0, q_aw.size() + q_w.size(), ERR_BURSTS);
    end
    n_vec++;
    if (error !== 1'b1) begin n_err++; $display("FAIL err_sticky: error %b, required 1", error); end
  endtask

  task automatic test_busy_restart();
    int d0 = done_cnt, b0 = b_cnt;
    bit ok;
    push_run(NB);
    pulse_start();
    repeat (20) @(posedge clk);
    #1;
    n_vec++;
    if (busy !== 1'b1 || error !== 1'b0) begin n_err++; $display("FAIL restart_busy: busy/error %b/%b, required 1/0", busy, error); end
    pulse_start();
    wait_done(d0, ok);
    repeat (20) @(posedge clk);
    n_vec++;
    if (!ok || done_cnt - d0 != 1 || b_cnt - b0 != NB) begin
      n_err++; $display("FAIL restart_len: done %0d bresp %0d, required 1/%0d", done_cnt - d0, b_cnt - b0, NB);
    end
    n_vec++;
    if (q_aw.size() + q_w.size() != 0 || error !== 1'b0) begin
      n_err++; $display("FAIL restart_end: left %0d error %b, required 0/0", q_aw.size() + q_w.size(), error);
    end
  endtask

  task automatic test_reset_mid();
    int d0 = done_cnt, b0, c = 0;
    bit ok;
    push_run(NB);
    pulse_start();
    while (q_w.size() > NB * BL - 20 && c < 200) begin @(posedge clk); c++; end
    #3 reset_n = 1'b0;
    #1;
    n_vec++;
    if ({awvalid, wvalid, wlast, bready, busy, done, error} !== 7'b0 || awaddr !== '0 || wdata !== 16'd100) begin
      n_err++; $display("FAIL midrst_outputs: ctrl %b addr %0d data %0d, required 0/0/100",
                        {awvalid, wvalid, wlast, bready, busy, done, error}, awaddr, wdata);
    end
    q_aw.delete(); q_w.delete();
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    repeat (10) @(posedge clk);
    n_vec++;
    if (done_cnt != d0) begin n_err++; $display("FAIL midrst_done: pulses %0d, required 0", done_cnt - d0); end
    b0 = b_cnt;
    push_run(NB);
    pulse_start();
    wait_done(d0, ok);
    n_vec++;
    if (!ok || done_cnt - d0 != 1 || b_cnt - b0 != NB || q_aw.size() + q_w.size() != 0) begin
      n_err++; $display("FAIL midrst_rerun: done %0d bresp %0d left %0d, required 1/%0d/0",
                        done_cnt - d0, b_cnt - b0, q_aw.size() + q_w.size(), NB);
    end
  endtask

  initial begin
    fork
      mon_loop();
      drv_loop();
    join_none
    test_reset();
    test_basic();
    test_stall(1'b0);
    test_stall(1'b1);
    test_burst1();
    test_error();
    test_busy_restart();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
